// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state, error-code and opcode-field definitions for instr_sequencer
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_FETCH,
        DECODE,
        EXEC_START,
        EXEC_WAIT,
        RETIRE,
        ERR
    } seq_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0] ERR_FETCH_TO = 2'd2;
    localparam logic [1:0] ERR_EXEC_TO  = 2'd3;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 4;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

endpackage

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - per-phase wait-state watchdog with clear-on-entry and expiry compare
module seq_watchdog #(
    parameter int WDOG_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  run,
    input  logic [WDOG_WIDTH-1:0] limit,
    output logic                  expired
);

    logic [WDOG_WIDTH-1:0] count;
    logic [WDOG_WIDTH-1:0] elapsed;

    // elapsed includes the current cycle, so a limit of N ends the wait after N cycles
    assign elapsed = count + WDOG_WIDTH'(1);
    assign expired = run && (limit != '0) && (elapsed == limit);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (run) begin
            count <= elapsed;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - top-level fetch/decode/execute sequencer with shared memory port arbitration
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 16,
    parameter int          DATA_WIDTH   = 8,
    parameter int          INSTR_WIDTH  = 64,
    parameter logic [31:0] OPCODE_LEGAL = 32'h0000_003E,
    parameter logic [4:0]  STORE_OPCODE = 5'd3,
    parameter int          WDOG_WIDTH   = 20,
    parameter int          CNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   resume,
    input  logic                   step_mode,
    input  logic [ADDR_WIDTH-1:0]  start_pc,
    input  logic                   abort,
    input  logic                   err_clear,
    input  logic [WDOG_WIDTH-1:0]  wdog_limit,
    output logic                   pc_load,
    output logic [ADDR_WIDTH-1:0]  pc_load_val,
    output logic                   fetch_en,
    input  logic                   fetch_done,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic [ADDR_WIDTH-1:0]  fetch_mem_addr,
    output logic [INSTR_WIDTH-1:0] ex_instr,
    output logic                   exec_start,
    output logic                   exec_abort,
    input  logic                   exec_done,
    input  logic [ADDR_WIDTH-1:0]  exec_mem_addr,
    input  logic                   exec_mem_we,
    input  logic [DATA_WIDTH-1:0]  exec_mem_wdata,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_we,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic                   result_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   step_done,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [CNT_WIDTH-1:0]   retired_cnt
);

    seq_state_t       state;
    logic [OPC_W-1:0] opcode;
    logic             in_wait;
    logic             wd_expired;

    assign opcode  = instr[OPC_MSB:OPC_LSB];
    assign in_wait = (state == WAIT_FETCH) || (state == EXEC_WAIT);

    seq_watchdog #(
        .WDOG_WIDTH(WDOG_WIDTH)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!in_wait),
        .run    (in_wait),
        .limit  (wdog_limit),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc_load      <= 1'b0;
            pc_load_val  <= '0;
            fetch_en     <= 1'b0;
            ex_instr     <= '0;
            exec_start   <= 1'b0;
            exec_abort   <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            step_done    <= 1'b0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
            retired_cnt  <= '0;
        end else begin
            pc_load    <= 1'b0;
            fetch_en   <= 1'b0;
            exec_start <= 1'b0;
            exec_abort <= 1'b0;
            done       <= 1'b0;
            step_done  <= 1'b0;
            if (abort && state != IDLE && state != ERR) begin
                state      <= IDLE;
                busy       <= 1'b0;
                exec_abort <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= FETCH;
                            busy     <= 1'b1;
                            fetch_en <= 1'b1;
                            if (!resume) begin
                                pc_load     <= 1'b1;
                                pc_load_val <= start_pc;
                                retired_cnt <= '0;
                            end
                        end
                    end
                    FETCH: state <= WAIT_FETCH;
                    WAIT_FETCH: begin
                        // a completed fetch beats a simultaneous watchdog expiry
                        if (fetch_done) begin
                            if (instr == '0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else if (!OPCODE_LEGAL[opcode]) begin
                                state    <= ERR;
                                busy     <= 1'b0;
                                err      <= 1'b1;
                                err_code <= ERR_ILLEGAL;
                            end else begin
                                state <= DECODE;
                            end
                        end else if (wd_expired) begin
                            state    <= ERR;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                            err_code <= ERR_FETCH_TO;
                        end
                    end
                    DECODE: begin
                        ex_instr   <= instr;
                        state      <= EXEC_START;
                        exec_start <= 1'b1;
                    end
                    EXEC_START: state <= EXEC_WAIT;
                    EXEC_WAIT: begin
                        if (exec_done) begin
                            state <= RETIRE;
                        end else if (wd_expired) begin
                            state    <= ERR;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                            err_code <= ERR_EXEC_TO;
                        end
                    end
                    RETIRE: begin
                        retired_cnt  <= retired_cnt + CNT_WIDTH'(1);
                        result_valid <= (ex_instr[OPC_MSB:OPC_LSB] != STORE_OPCODE);
                        if (step_mode) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            step_done <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            fetch_en <= 1'b1;
                        end
                    end
                    ERR: begin
                        if (err_clear) begin
                            state    <= IDLE;
                            err      <= 1'b0;
                            err_code <= ERR_NONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // fetch owns the port while fetching; no writes leak out while idle or in error
    always_comb begin
        mem_addr  = exec_mem_addr;
        mem_we    = exec_mem_we;
        mem_wdata = exec_mem_wdata;
        if (state == FETCH || state == WAIT_FETCH) begin
            mem_addr  = fetch_mem_addr;
            mem_we    = 1'b0;
            mem_wdata = '0;
        end else if (state == IDLE || state == ERR) begin
            mem_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

    localparam logic [63:0] I_OP1   = 64'h1234_5678_0000_0001;
    localparam logic [63:0] I_OP2   = 64'h00AB_0000_0000_0022;
    localparam logic [63:0] I_STORE = 64'h0000_00C0_0000_0063;
    localparam logic [63:0] I_ILL   = 64'h0000_0000_0000_0007;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, resume, step_mode, abort, err_clear;
    logic [15:0] start_pc;
    logic [19:0] wdog_limit;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        fetch_en;
    logic        fetch_done;
    logic [63:0] instr;
    logic [15:0] fetch_mem_addr;
    logic [63:0] ex_instr;
    logic        exec_start, exec_abort, exec_done;
    logic [15:0] exec_mem_addr;
    logic        exec_mem_we;
    logic [7:0]  exec_mem_wdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        result_valid, busy, done, step_done, err;
    logic [1:0]  err_code;
    logic [15:0] retired_cnt;

    logic [63:0] prog [0:3];
    logic        fetch_auto, exec_auto;
    int          fetch_idx;
    int          cnt_done, cnt_step_done, cnt_exec_start, cnt_pc_load, cnt_exec_abort;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .resume(resume), .step_mode(step_mode),
        .start_pc(start_pc), .abort(abort), .err_clear(err_clear), .wdog_limit(wdog_limit),
        .pc_load(pc_load), .pc_load_val(pc_load_val), .fetch_en(fetch_en),
        .fetch_done(fetch_done), .instr(instr), .fetch_mem_addr(fetch_mem_addr),
        .ex_instr(ex_instr), .exec_start(exec_start), .exec_abort(exec_abort),
        .exec_done(exec_done), .exec_mem_addr(exec_mem_addr), .exec_mem_we(exec_mem_we),
        .exec_mem_wdata(exec_mem_wdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .result_valid(result_valid), .busy(busy), .done(done),
        .step_done(step_done), .err(err), .err_code(err_code), .retired_cnt(retired_cnt)
    );

    // fetch/execute unit models plus pulse monitors, acting 1 time unit after each edge
    initial begin
        logic fpend, epend;
        fpend = 1'b0; epend = 1'b0;
        fetch_done = 1'b0; exec_done = 1'b0; instr = '0; fetch_idx = 0;
        cnt_done = 0; cnt_step_done = 0; cnt_exec_start = 0; cnt_pc_load = 0; cnt_exec_abort = 0;
        forever begin
            @(posedge clk);
            #1;
            fetch_done = 1'b0;
            exec_done  = 1'b0;
            if (!rst_n) begin
                fpend = 1'b0; epend = 1'b0;
            end else begin
                if (fpend && fetch_auto) begin
                    fetch_done = 1'b1;
                    instr      = prog[fetch_idx];
                    fetch_idx  = fetch_idx + 1;
                end
                fpend = 1'b0;
                if (epend && exec_auto) exec_done = 1'b1;
                epend = 1'b0;
                if (pc_load) begin
                    fetch_idx   = 0;
                    cnt_pc_load = cnt_pc_load + 1;
                end
                if (fetch_en) fpend = 1'b1;
                if (exec_start) begin
                    epend = 1'b1;
                    cnt_exec_start = cnt_exec_start + 1;
                end
                if (done) cnt_done = cnt_done + 1;
                if (step_done) cnt_step_done = cnt_step_done + 1;
                if (exec_abort) cnt_exec_abort = cnt_exec_abort + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic res);
        resume = res;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if ({pc_load, fetch_en, exec_start, exec_abort, busy, done, step_done, err, result_valid, mem_we} !== 10'b0) begin
            n_fail++; $display("FAIL reset_flags got %b expected 0", {pc_load, fetch_en, exec_start, exec_abort, busy, done, step_done, err, result_valid, mem_we});
        end
        n_checks++;
        if (retired_cnt !== 16'd0 || err_code !== 2'd0 || ex_instr !== 64'd0) begin
            n_fail++; $display("FAIL reset_regs got cnt=%0d code=%0d ex=%h expected 0", retired_cnt, err_code, ex_instr);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_program();
        int b_done, b_es, b_pl;
        prog[0] = I_OP1; prog[1] = I_OP2; prog[2] = 64'd0;
        b_done = cnt_done; b_es = cnt_exec_start; b_pl = cnt_pc_load;
        start_pc = 16'h0040; step_mode = 1'b0;
        pulse_start(1'b0);
        n_checks++;
        if (pc_load !== 1'b1 || pc_load_val !== 16'h0040) begin
            n_fail++; $display("FAIL prog_pc_load got %b/%h expected 1/0040", pc_load, pc_load_val);
        end
        for (int i = 0; i < 100 && cnt_done == b_done; i++) tick();
        n_checks++;
        if (cnt_done - b_done !== 1) begin
            n_fail++; $display("FAIL prog_done got %0d pulses expected 1", cnt_done - b_done);
        end
        n_checks++;
        if (cnt_exec_start - b_es !== 2 || cnt_pc_load - b_pl !== 1) begin
            n_fail++; $display("FAIL prog_pulses got es=%0d pl=%0d expected 2/1", cnt_exec_start - b_es, cnt_pc_load - b_pl);
        end
        n_checks++;
        if (retired_cnt !== 16'd2 || result_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL prog_final got cnt=%0d rv=%b busy=%b expected 2/1/0", retired_cnt, result_valid, busy);
        end
        n_checks++;
        if (ex_instr !== I_OP2) begin
            n_fail++; $display("FAIL prog_ex_instr got %h expected %h", ex_instr, I_OP2);
        end
    endtask

    task automatic test_step();
        int b_sd, b_es, b_pl, b_done;
        prog[0] = I_OP1; prog[1] = I_OP2; prog[2] = 64'd0;
        step_mode = 1'b1; start_pc = 16'h0040;
        b_sd = cnt_step_done; b_es = cnt_exec_start; b_pl = cnt_pc_load; b_done = cnt_done;
        pulse_start(1'b0);
        for (int i = 0; i < 50 && cnt_step_done == b_sd; i++) tick();
        n_checks++;
        if (cnt_step_done - b_sd !== 1 || cnt_exec_start - b_es !== 1 || retired_cnt !== 16'd1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL step_first got sd=%0d es=%0d cnt=%0d busy=%b expected 1/1/1/0",
                               cnt_step_done - b_sd, cnt_exec_start - b_es, retired_cnt, busy);
        end
        pulse_start(1'b1);
        n_checks++;
        if (pc_load !== 1'b0 || fetch_en !== 1'b1) begin
            n_fail++; $display("FAIL step_resume got pc_load=%b fetch_en=%b expected 0/1", pc_load, fetch_en);
        end
        for (int i = 0; i < 50 && cnt_step_done - b_sd < 2; i++) tick();
        n_checks++;
        if (cnt_step_done - b_sd !== 2 || retired_cnt !== 16'd2 || ex_instr !== I_OP2 || cnt_pc_load - b_pl !== 1) begin
            n_fail++; $display("FAIL step_second got sd=%0d cnt=%0d ex=%h pl=%0d expected 2/2/%h/1",
                               cnt_step_done - b_sd, retired_cnt, ex_instr, cnt_pc_load - b_pl, I_OP2);
        end
        pulse_start(1'b1);
        for (int i = 0; i < 50 && cnt_done == b_done; i++) tick();
        n_checks++;
        if (cnt_done - b_done !== 1 || retired_cnt !== 16'd2) begin
            n_fail++; $display("FAIL step_end got done=%0d cnt=%0d expected 1/2", cnt_done - b_done, retired_cnt);
        end
        step_mode = 1'b0;
    endtask

    task automatic test_illegal();
        int b_es;
        prog[0] = I_ILL; prog[1] = 64'd0;
        b_es = cnt_exec_start;
        pulse_start(1'b0);
        for (int i = 0; i < 50 && err !== 1'b1; i++) tick();
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'd1 || cnt_exec_start - b_es !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL illegal_err got err=%b code=%0d es=%0d busy=%b expected 1/1/0/0",
                               err, err_code, cnt_exec_start - b_es, busy);
        end
        pulse_start(1'b0);
        tick();
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0 || fetch_en !== 1'b0) begin
            n_fail++; $display("FAIL illegal_start_ignored got err=%b code=%0d busy=%b fe=%b expected 1/1/0/0",
                               err, err_code, busy, fetch_en);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        n_checks++;
        if (err !== 1'b0 || err_code !== 2'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL illegal_clear got err=%b code=%0d busy=%b expected 0/0/0", err, err_code, busy);
        end
    endtask

    task automatic test_watchdog();
        prog[0] = I_OP1; prog[1] = 64'd0;
        exec_auto = 1'b0; wdog_limit = 20'd5;
        pulse_start(1'b0);
        for (int i = 0; i < 50 && exec_start !== 1'b1; i++) tick();
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++;
            if (err !== 1'b0) begin
                n_fail++; $display("FAIL wdog_early cycle %0d got err=%b expected 0", k, err);
            end
        end
        tick();
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'd3) begin
            n_fail++; $display("FAIL wdog_expire got err=%b code=%0d expected 1/3", err, err_code);
        end
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        wdog_limit = 20'd0;
        pulse_start(1'b0);
        for (int i = 0; i < 50 && exec_start !== 1'b1; i++) tick();
        for (int i = 0; i < 1000; i++) tick();
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL wdog_disabled got err=%b busy=%b expected 0/1", err, busy);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        exec_auto = 1'b1;
    endtask

    task automatic test_abort();
        int b_done, b_ea;
        prog[0] = I_OP1; prog[1] = I_OP2; prog[2] = 64'd0;
        step_mode = 1'b1;
        pulse_start(1'b0);
        for (int i = 0; i < 50 && busy === 1'b1; i++) tick();
        step_mode = 1'b0; exec_auto = 1'b0;
        b_done = cnt_done; b_ea = cnt_exec_abort;
        pulse_start(1'b1);
        for (int i = 0; i < 50 && exec_start !== 1'b1; i++) tick();
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (exec_abort !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_pulse got ea=%b busy=%b done=%b expected 1/0/0", exec_abort, busy, done);
        end
        tick(); tick();
        n_checks++;
        if (retired_cnt !== 16'd1 || cnt_done - b_done !== 0 || cnt_exec_abort - b_ea !== 1 || exec_abort !== 1'b0) begin
            n_fail++; $display("FAIL abort_after got cnt=%0d done=%0d ea=%0d/%b expected 1/0/1/0",
                               retired_cnt, cnt_done - b_done, cnt_exec_abort - b_ea, exec_abort);
        end
        exec_auto = 1'b1;
    endtask

    task automatic test_reset_mid();
        prog[0] = I_OP1; prog[1] = 64'd0;
        step_mode = 1'b1; start_pc = 16'h1234;
        pulse_start(1'b0);
        for (int i = 0; i < 50 && busy === 1'b1; i++) tick();
        step_mode = 1'b0; fetch_auto = 1'b0;
        pulse_start(1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({pc_load, fetch_en, exec_start, exec_abort, busy, done, step_done, err, result_valid, mem_we} !== 10'b0 ||
            retired_cnt !== 16'd0 || ex_instr !== 64'd0 || pc_load_val !== 16'd0 || mem_addr !== 16'd0 || mem_wdata !== 8'd0) begin
            n_fail++; $display("FAIL reset_mid got flags=%b cnt=%0d ex=%h plv=%h addr=%h expected all 0",
                               {pc_load, fetch_en, exec_start, exec_abort, busy, done, step_done, err, result_valid, mem_we},
                               retired_cnt, ex_instr, pc_load_val, mem_addr);
        end
        rst_n = 1'b1; fetch_auto = 1'b1;
        tick();
    endtask

    task automatic test_store_and_mem();
        int b_done;
        prog[0] = I_OP1; prog[1] = I_STORE; prog[2] = 64'd0;
        b_done = cnt_done;
        pulse_start(1'b0);
        for (int i = 0; i < 100 && cnt_done == b_done; i++) tick();
        n_checks++;
        if (result_valid !== 1'b0 || retired_cnt !== 16'd2 || cnt_done - b_done !== 1) begin
            n_fail++; $display("FAIL store_rv got rv=%b cnt=%0d done=%0d expected 0/2/1", result_valid, retired_cnt, cnt_done - b_done);
        end
        exec_mem_addr = 16'hBEEF; exec_mem_we = 1'b1; exec_mem_wdata = 8'h5A; fetch_mem_addr = 16'h0F0F;
        exec_auto = 1'b0;
        tick();
        n_checks++;
        if (mem_we !== 1'b0 || mem_addr !== 16'hBEEF) begin
            n_fail++; $display("FAIL mem_idle got we=%b addr=%h expected 0/beef", mem_we, mem_addr);
        end
        pulse_start(1'b0);
        n_checks++;
        if (mem_we !== 1'b0 || mem_addr !== 16'h0F0F || mem_wdata !== 8'h00) begin
            n_fail++; $display("FAIL mem_fetch got we=%b addr=%h wd=%h expected 0/0f0f/00", mem_we, mem_addr, mem_wdata);
        end
        tick();
        n_checks++;
        if (mem_we !== 1'b0 || mem_addr !== 16'h0F0F) begin
            n_fail++; $display("FAIL mem_wait_fetch got we=%b addr=%h expected 0/0f0f", mem_we, mem_addr);
        end
        tick();
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 16'hBEEF || mem_wdata !== 8'h5A) begin
            n_fail++; $display("FAIL mem_exec got we=%b addr=%h wd=%h expected 1/beef/5a", mem_we, mem_addr, mem_wdata);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        exec_mem_addr = '0; exec_mem_we = 1'b0; exec_mem_wdata = '0; exec_auto = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; resume = 1'b0; step_mode = 1'b0; abort = 1'b0; err_clear = 1'b0;
        start_pc = '0; wdog_limit = '0; fetch_mem_addr = '0;
        exec_mem_addr = '0; exec_mem_we = 1'b0; exec_mem_wdata = '0;
        fetch_auto = 1'b1; exec_auto = 1'b1;
        for (int i = 0; i < 4; i++) prog[i] = 64'd0;
        test_reset();
        test_program();
        test_step();
        test_illegal();
        test_watchdog();
        test_abort();
        test_reset_mid();
        test_store_and_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
